// File: rtl/seq_pkg.sv
// Shared types and constants for the serial bit-stream transmitter and its pattern tracker.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Pattern the downstream detector looks for, oldest bit in the MSB.
    localparam int unsigned         PAT_LEN = 4;
    localparam logic [PAT_LEN-1:0]  PATTERN = 4'b1011;

    // Reset values.
    localparam state_e              RST_STATE     = IDLE;
    localparam logic                RST_BIT_VALID = 1'b0;
    localparam logic                RST_BUSY      = 1'b0;
    localparam logic                RST_DONE      = 1'b0;
    localparam logic                RST_EXP_OUT   = 1'b0;
    localparam logic [PAT_LEN-2:0]  RST_HISTORY   = '0;

endpackage

// File: rtl/seq_pat_track.sv
// Overlapping "1011" tracker: mirrors a Moore detector fed by bit_in and counts its hits.
module seq_pat_track
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic             exp_out
);

    logic [PAT_LEN-2:0] history;
    logic [PAT_LEN-1:0] window;
    logic               hit;

    assign window = {history, bit_in};
    assign hit    = (window == PATTERN);

    // History shifts every cycle, idle or not; exp_out lags the window by one like a Moore output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            history <= RST_HISTORY;
            exp_out <= RST_EXP_OUT;
        end else begin
            history <= window[PAT_LEN-2:0];
            exp_out <= hit;
        end
    end

    // Saturating hit counter; a clear wins over a coincident hit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (hit && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_bit_tx.sv
// Parallel-in, MSB-first serial transmitter with gapless back-to-back loads and a pattern tracker.
module seq_bit_tx
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic             exp_out
);

    localparam int unsigned        IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] bit_idx;
    logic             accept;

    // Ready on the last bit too, so the next word follows without a gap.
    assign load_ready = (state == IDLE) || (state == DONE) ||
                        ((state == SHIFT) && (bit_idx == LAST_IDX));
    assign accept     = load_valid && load_ready;

    // Transmit FSM with registered line outputs; MSB goes straight to bit_out on acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RST_STATE;
            shreg     <= '0;
            bit_idx   <= '0;
            bit_out   <= IDLE_BIT;
            bit_valid <= RST_BIT_VALID;
            busy      <= RST_BUSY;
            done      <= RST_DONE;
        end else if (accept) begin
            state     <= SHIFT;
            shreg     <= {data_in[WIDTH-2:0], 1'b0};
            bit_idx   <= '0;
            bit_out   <= data_in[WIDTH-1];
            bit_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            unique case (state)
                SHIFT: begin
                    if (bit_idx == LAST_IDX) begin
                        state     <= DONE;
                        bit_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        bit_out <= shreg[WIDTH-1];
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    bit_out   <= IDLE_BIT;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    seq_pat_track #(
        .CNT_W (CNT_W)
    ) u_track (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_out),
        .clr_cnt   (clr_cnt),
        .match_cnt (match_cnt),
        .exp_out   (exp_out)
    );

endmodule

// File: tb/tb_seq_bit_tx.sv
// Scoreboard bench for seq_bit_tx: driver pushes expected line bits, monitor checks every cycle.
module tb_seq_bit_tx;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CNT_W   = 5;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic        IDLE_B  = 1'b0;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic             clr_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic             exp_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: bits the line must carry, in order, starting the cycle after acceptance.
    bit exp_q[$];
    bit mon_en   = 1'b0;
    bit rand_clr = 1'b0;

    // Pattern-level reference state.
    int line_q[$];
    int m_cnt      = 0;
    bit m_exp      = 1'b0;
    bit last_line  = 1'b0;
    bit last_valid = 1'b0;
    int pat[4]     = '{1, 0, 1, 1};

    seq_bit_tx #(
        .WIDTH    (WIDTH),
        .IDLE_BIT (IDLE_B),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done),
        .clr_cnt    (clr_cnt),
        .match_cnt  (match_cnt),
        .exp_out    (exp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: first account for the edge just passed, then check the current cycle.
    always @(negedge clk) begin
        bit e_valid;
        bit e_bit;
        bit win_hit;
        if (!rst) begin
            exp_q.delete();
            line_q.delete();
            repeat (3) line_q.push_back(0);
            m_cnt      = 0;
            m_exp      = 1'b0;
            last_valid = 1'b0;
        end else begin
            line_q.push_back(int'(last_line));
            win_hit = 1'b1;
            for (int i = 0; i < 4; i++) if (line_q[i] != pat[i]) win_hit = 1'b0;
            m_exp = win_hit;
            if (clr_cnt) m_cnt = 0;
            else if (win_hit && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            void'(line_q.pop_front());
        end
        e_valid = (exp_q.size() > 0);
        e_bit   = e_valid ? exp_q.pop_front() : IDLE_B;
        if (mon_en) begin
            chk("bit_valid", 32'(bit_valid), 32'(e_valid));
            chk("bit_out", 32'(bit_out), 32'(e_bit));
            chk("busy", 32'(busy), 32'(e_valid));
            chk("done", 32'(done), 32'(last_valid && !e_valid));
            chk("load_ready", 32'(load_ready), 32'(exp_q.size() == 0));
            chk("exp_out", 32'(exp_out), 32'(m_exp));
            chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        end
        last_line  = e_bit;
        last_valid = e_valid;
    end

    // Inputs for the current cycle are set by the caller, then time moves to the next cycle.
    task automatic step();
        clr_cnt = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            load_valid = 1'b0;
            step();
        end
    endtask

    // Offer a word; garbage rides on data_in while held off, so an early capture shows up.
    task automatic send(input logic [WIDTH-1:0] w);
        int guard = 0;
        load_valid = 1'b1;
        while (exp_q.size() != 0) begin
            data_in = WIDTH'($urandom);
            step();
            guard++;
            if (guard > 40) begin
                n_fail++;
                $display("FAIL handshake_timeout: got no ready expected ready within 40 cycles");
                return;
            end
        end
        data_in = w;
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
        step();
    endtask

    task automatic pulse_rst();
        load_valid = 1'b0;
        rst        = 1'b0;
        step();
        rst        = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        clr_cnt    = 1'b0;
        data_in    = '0;
        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        idle(3);

        // Single word from idle.
        send(8'hB0);
        idle(10);
        // Back-to-back words, overlapping matches.
        send(8'hB6);
        send(8'h00);
        idle(10);
        // Match spanning a word boundary.
        send(8'h01);
        send(8'h60);
        idle(10);
        // Second word held off for the whole first word.
        send(8'hA5);
        send(8'h3C);
        idle(10);
        // Reset with bit 3 of 0xFF on the line, then a clean word.
        send(8'hFF);
        idle(3);
        pulse_rst();
        send(8'hB0);
        idle(10);
        // Clear coinciding with the fourth match.
        pulse_rst();
        repeat (3) begin
            send(8'hB0);
            idle(9);
        end
        send(8'hB0);
        idle(3);
        load_valid = 1'b0;
        clr_cnt    = 1'b1;
        @(negedge clk);
        #1;
        clr_cnt = 1'b0;
        idle(8);
        send(8'hB0);
        idle(10);
        // Saturation: continuous 101101... stream.
        repeat (5) begin
            send(8'hB6);
            send(8'hDB);
            send(8'h6D);
        end
        idle(10);
        // Random words, gaps and clears.
        rand_clr = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(WIDTH'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 10));
        end
        rand_clr = 1'b0;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected end before time limit");
        $fatal(1, "watchdog");
    end

endmodule
